// File: rtl/seg7_pkg.sv
// Shared glyph constants, display-code encoding and sizing helpers for the
// seven-segment scan driver.
package seg7_pkg;

  // Display buffer entry: 0-15 select a hex/decimal glyph, the rest are symbols.
  typedef logic [4:0] code_t;

  localparam code_t CODE_BLANK = 5'd16;
  localparam code_t CODE_MINUS = 5'd17;
  localparam code_t CODE_E     = 5'd18;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  function automatic int bcd_digits(input int w);
    return (w * 3) / 10 + 1;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; b and d are the lowercase forms.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per clock, VALUE_W steps,
// then one cycle with done high while the finished BCD value is presented.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int VALUE_W = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [VALUE_W-1:0]                bin,
  output logic                              busy,
  output logic                              done,
  output logic [bcd_digits(VALUE_W)*4-1:0]  bcd
);
  localparam int BCD_D = bcd_digits(VALUE_W);
  localparam int BCD_W = BCD_D * 4;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    adj    = bcd_q;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (start && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(VALUE_W);
      bin_d  = bin;
      bcd_d  = '0;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        bcd_d = {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver: captures a signed result, converts it
// to decimal or hex, formats sign/blanking/overflow and scans the anodes.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int VALUE_W     = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [VALUE_W-1:0]  value,
  input  logic                load,
  input  logic                mode_toggle,
  input  logic                blank_lz,
  output logic                busy,
  output logic                hex_mode,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an
);
  localparam int BCD_D = bcd_digits(VALUE_W);
  localparam int BCD_W = BCD_D * 4;
  localparam int RAW_D = (BCD_D > N_DIGITS) ? BCD_D : N_DIGITS;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  typedef logic [RAW_D*4-1:0]   raw_vec_t;
  typedef code_t [N_DIGITS-1:0] disp_t;

  logic               mode_prev_q, mode_prev_d;
  logic               hex_mode_q, hex_mode_d;
  logic               pending_q, pending_d;
  logic               hex_busy_q, hex_busy_d;
  logic               conv_hex_q, conv_hex_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic [VALUE_W-1:0] mag_q, mag_d;
  logic               neg_q, neg_d;
  logic               blz_q, blz_d;
  disp_t              buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic               mode_edge, start, dec_start, commit;
  logic [VALUE_W-1:0] src;
  logic               dec_busy, dec_done;
  logic [BCD_W-1:0]   bcd;
  raw_vec_t           raw_vec;
  logic [3:0]         raw [RAW_D];
  int                 nd;
  logic               ovf;
  disp_t              fmt;
  code_t              cur;
  logic [N_DIGITS-1:0] one_hot;

  assign busy = hex_busy_q | dec_busy;

  // An idle mode edge or leftover pending request re-converts the held value.
  always_comb begin
    mode_edge   = mode_toggle && !mode_prev_q;
    start       = !busy && (load || mode_edge || pending_q);
    src         = load ? value : val_q;
    mode_prev_d = mode_toggle;
    hex_mode_d  = hex_mode_q ^ mode_edge;
    pending_d   = start ? 1'b0 : (pending_q || mode_edge);
    val_d       = val_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    blz_d       = blz_q;
    conv_hex_d  = conv_hex_q;
    if (start) begin
      val_d      = src;
      neg_d      = src[VALUE_W-1];
      mag_d      = src[VALUE_W-1] ? (~src + 1'b1) : src;
      blz_d      = blank_lz;
      conv_hex_d = hex_mode_d;
    end
    hex_busy_d = start && hex_mode_d;
    dec_start  = start && !hex_mode_d;
    commit     = hex_busy_q || dec_done;
  end

  bin2bcd_seq #(.VALUE_W(VALUE_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (dec_start),
    .bin   (mag_d),
    .busy  (dec_busy),
    .done  (dec_done),
    .bcd   (bcd)
  );

  // Upper nibbles of both sources are zero-padded so hex and decimal share one path.
  always_comb begin
    raw_vec = conv_hex_q ? raw_vec_t'(mag_q) : raw_vec_t'(bcd);
    nd = 1;
    for (int i = 0; i < RAW_D; i++) begin
      raw[i] = raw_vec[4*i +: 4];
      if (raw_vec[4*i +: 4] != 4'd0) nd = i + 1;
    end
    ovf = (nd + (neg_q ? 1 : 0)) > N_DIGITS;
    for (int i = 0; i < N_DIGITS; i++) begin
      fmt[i] = CODE_BLANK;
      if (ovf) begin
        if (i == N_DIGITS - 1) fmt[i] = CODE_E;
      end else if (blz_q) begin
        if (i < nd) fmt[i] = {1'b0, raw[i]};
        else if (i == nd && neg_q) fmt[i] = CODE_MINUS;
      end else begin
        if (neg_q && i == N_DIGITS - 1) fmt[i] = CODE_MINUS;
        else fmt[i] = {1'b0, raw[i]};
      end
    end
    buf_d = commit ? fmt : buf_q;
  end

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    cur = buf_q[idx_q];
    case (cur)
      CODE_BLANK: seg_d = SEG_BLANK;
      CODE_MINUS: seg_d = SEG_MINUS;
      CODE_E:     seg_d = SEG_E;
      default:    seg_d = glyph(cur[3:0]);
    endcase
    one_hot        = '0;
    one_hot[idx_q] = 1'b1;
    an_d           = ~one_hot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_prev_q <= 1'b0;
      hex_mode_q  <= 1'b0;
      pending_q   <= 1'b0;
      hex_busy_q  <= 1'b0;
      conv_hex_q  <= 1'b0;
      val_q       <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      blz_q       <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) buf_q[i] <= (i == 0) ? 5'd0 : CODE_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_q       <= glyph(4'd0);
      an_q        <= {{(N_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      mode_prev_q <= mode_prev_d;
      hex_mode_q  <= hex_mode_d;
      pending_q   <= pending_d;
      hex_busy_q  <= hex_busy_d;
      conv_hex_q  <= conv_hex_d;
      val_q       <= val_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      blz_q       <= blz_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign hex_mode = hex_mode_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a 4-digit and a 2-digit driver (REFRESH_DIV=4); expected
// display strings are queued at stimulus time and compared when conversions end.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] value_a, value_b;
  logic       load_a, load_b, tog_a, tog_b, blz_a, blz_b;
  logic       busy_a, busy_b, hex_a, hex_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a;
  logic [1:0] an_b;

  int    n_chk = 0;
  int    n_pass = 0;
  string exp_q[$];

  seg7_scan_driver #(.N_DIGITS(4), .VALUE_W(8), .REFRESH_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .value(value_a), .load(load_a), .mode_toggle(tog_a),
    .blank_lz(blz_a), .busy(busy_a), .hex_mode(hex_a), .seg(seg_a), .an(an_a)
  );

  seg7_scan_driver #(.N_DIGITS(2), .VALUE_W(8), .REFRESH_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .value(value_b), .load(load_b), .mode_toggle(tog_b),
    .blank_lz(blz_b), .busy(busy_b), .hex_mode(hex_b), .seg(seg_b), .an(an_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [6:0] ch_glyph(input byte c);
    case (c)
      "0": return 7'h40;  "1": return 7'h79;  "2": return 7'h24;  "3": return 7'h30;
      "4": return 7'h19;  "5": return 7'h12;  "6": return 7'h02;  "7": return 7'h78;
      "8": return 7'h00;  "9": return 7'h10;  "A": return 7'h08;  "b": return 7'h03;
      "C": return 7'h46;  "d": return 7'h21;  "E": return 7'h06;  "F": return 7'h0E;
      "-": return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Leftmost character is the highest digit.
  function automatic logic [27:0] str_segs(input string s);
    logic [27:0] r;
    int n;
    r = '0;
    n = s.len();
    for (int i = 0; i < n; i++) r[7*(n-1-i) +: 7] = ch_glyph(s[i]);
    return r;
  endfunction

  task automatic read_disp(input int w, output logic [27:0] r);
    logic [3:0] an_w;
    logic [6:0] seg_w;
    r = '0;
    repeat (20) begin
      tick();
      an_w  = (w == 1) ? {2'b11, an_b} : an_a;
      seg_w = (w == 1) ? seg_b : seg_a;
      for (int d = 0; d < 4; d++) if (an_w[d] == 1'b0) r[7*d +: 7] = seg_w;
    end
  endtask

  task automatic check_disp(input int w);
    logic [27:0] got;
    string s;
    read_disp(w, got);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      s = exp_q.pop_front();
      check({"disp[", s, "]"}, {4'b0, got}, {4'b0, str_segs(s)});
    end
  endtask

  // Entered on the first cycle after the start edge; counts busy cycles and checks
  // that the previous display stays intact while the conversion runs.
  task automatic run_conv(input int w, input int exp_busy, input string old);
    int bc;
    int bad;
    logic [27:0] og;
    logic [3:0]  an_w;
    logic [6:0]  seg_w;
    bc  = 0;
    bad = 0;
    og  = str_segs(old);
    while (((w == 1) ? busy_b : busy_a) && bc < 40) begin
      an_w  = (w == 1) ? {2'b11, an_b} : an_a;
      seg_w = (w == 1) ? seg_b : seg_a;
      for (int d = 0; d < 4; d++) if (an_w[d] == 1'b0 && seg_w !== og[7*d +: 7]) bad++;
      bc++;
      tick();
    end
    check("busy_len", bc, exp_busy);
    check("held_old", bad, 0);
    check_disp(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [3:0] exp_an;
    reset = 1'b1;
    value_a = '0; load_a = 1'b0; tog_a = 1'b0; blz_a = 1'b0;
    value_b = '0; load_b = 1'b0; tog_b = 1'b0; blz_b = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy_a, 1'b0);
    check("rst_hex", hex_a, 1'b0);
    check("rst_an", an_a, 4'b1110);
    check("rst_seg", seg_a, 7'b1000000);
    check("rst_an_b", an_b, 2'b10);
    reset = 1'b0;

    // Anode scan: after leaving digit 0, each digit is lit for 4 clocks in order.
    k = 0;
    while (an_a == 4'b1110 && k < 20) begin tick(); k++; end
    for (int j = 0; j < 24; j++) begin
      exp_an = ~(4'b0001 << ((1 + j / 4) % 4));
      check("an_scan", an_a, exp_an);
      tick();
    end
    exp_q.push_back("   0");
    check_disp(0);

    // -128 decimal with blanking.
    value_a = 8'h80; blz_a = 1'b1; load_a = 1'b1;
    exp_q.push_back("-128");
    tick(); load_a = 1'b0;
    run_conv(0, 9, "   0");

    // Edge alone re-converts held -128 in hex, then -91 in hex.
    tog_a = 1'b1;
    exp_q.push_back(" -80");
    tick(); tog_a = 1'b0;
    run_conv(0, 1, "-128");
    check("hex_on", hex_a, 1'b1);
    value_a = 8'hA5; load_a = 1'b1;
    exp_q.push_back(" -5b");
    tick(); load_a = 1'b0;
    run_conv(0, 1, " -80");

    // Load and edge together: back to decimal with the new value, no blanking.
    value_a = 8'd31; blz_a = 1'b0; load_a = 1'b1; tog_a = 1'b1;
    exp_q.push_back("0031");
    tick(); load_a = 1'b0; tog_a = 1'b0;
    run_conv(0, 9, " -5b");
    check("dec_on", hex_a, 1'b0);
    tick();
    // Held-high toggle gives exactly one flip and a load-free re-conversion.
    tog_a = 1'b1;
    exp_q.push_back("001F");
    tick();
    run_conv(0, 1, "0031");
    tog_a = 1'b0;
    check("one_flip", hex_a, 1'b1);
    check("no_reconv", busy_a, 1'b0);
    tick();

    // Load and edge during a decimal conversion: load ignored, edge re-converts afterwards.
    value_a = 8'd42; blz_a = 1'b1; load_a = 1'b1; tog_a = 1'b1;
    exp_q.push_back("  2A");
    tick(); load_a = 1'b0; tog_a = 1'b0;
    tick(); value_a = 8'd5; load_a = 1'b1; tog_a = 1'b1;
    tick(); load_a = 1'b0; tog_a = 1'b0;
    k = 0;
    while (busy_a && k < 40) begin tick(); k++; end
    check("pend_len", k + 2, 9);
    check("pend_gap", busy_a, 1'b0);
    tick();
    check("pend_restart", busy_a, 1'b1);
    check("pend_hex", hex_a, 1'b1);
    tick();
    check("pend_done", busy_a, 1'b0);
    check_disp(0);

    // Reset in the middle of a decimal conversion.
    value_a = 8'd99; load_a = 1'b1; tog_a = 1'b1;
    tick(); load_a = 1'b0; tog_a = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_q.push_back("   0");
    tick();
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_hex", hex_a, 1'b0);
    reset = 1'b0;
    check_disp(0);

    // Two-digit overflow and sign cases.
    value_b = 8'd100; load_b = 1'b1;
    exp_q.push_back("E ");
    tick(); load_b = 1'b0;
    run_conv(1, 9, " 0");
    value_b = 8'hF7; load_b = 1'b1;
    exp_q.push_back("-9");
    tick(); load_b = 1'b0;
    run_conv(1, 9, "E ");
    value_b = 8'hF6; load_b = 1'b1;
    exp_q.push_back("E ");
    tick(); load_b = 1'b0;
    run_conv(1, 9, "-9");
    value_b = 8'h80; load_b = 1'b1; tog_b = 1'b1;
    exp_q.push_back("E ");
    tick(); load_b = 1'b0; tog_b = 1'b0;
    run_conv(1, 1, "E ");
    check("b_hex", hex_b, 1'b1);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
